// File: rtl/uart_rx_if.sv
// Byte-delivery bundle between the UART receive front end (master) and the
// UART control block (slave): serial pin, FIFO not-full, data and status strobes.
interface uart_rx_if;
    logic       i_rxd;
    logic       i_rx_notfull;
    logic [7:0] o_rx_data;
    logic       o_irq;
    logic       o_rx_busy;
    logic       o_frame_err;
    logic       o_overrun;

    modport master (
        input  i_rxd,
        input  i_rx_notfull,
        output o_rx_data,
        output o_irq,
        output o_rx_busy,
        output o_frame_err,
        output o_overrun
    );

    modport slave (
        output i_rxd,
        output i_rx_notfull,
        input  o_rx_data,
        input  o_irq,
        input  o_rx_busy,
        input  o_frame_err,
        input  o_overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the RX pin, 2-of-3 majority vote at mid-bit,
// and delivers each byte on a one-cycle strobe with frame-error/overrun status.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_if.master    bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int M  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_S0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(M);
    localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic          rxd_meta, rxs;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          s0_q, s0_d, s1_q, s1_d;
    logic          irq_q, irq_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          busy_q;
    logic          maj;

    // Idle-high line, so the synchronizer resets to 1 to avoid a fake start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= bus.i_rxd;
            rxs      <= rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            irq_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            irq_q   <= irq_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // The third vote is the live rxs at the decision count.
    assign maj = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        irq_d   = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (cnt_q == CNT_S0) s0_d = rxs;
        if (cnt_q == CNT_S1) s1_d = rxs;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_DEC && maj) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (cnt_q == CNT_DEC) shreg_d[idx_q] = maj;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
                if (cnt_q == CNT_DEC) begin
                    cnt_d = '0;
                    if (maj) begin
                        state_d = IDLE;
                        if (bus.i_rx_notfull) begin
                            data_d = shreg_q;
                            irq_d  = 1'b1;
                        end else begin
                            ovr_d  = 1'b1;
                        end
                    end else begin
                        state_d = BREAK;
                        ferr_d  = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.o_rx_data   = data_q;
    assign bus.o_irq       = irq_q;
    assign bus.o_frame_err = ferr_q;
    assign bus.o_overrun   = ovr_q;
    assign bus.o_rx_busy   = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: single byte, overrun,
// back-to-back frames, framing error/break, false start and reset mid-frame.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int M   = CPB / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int irq_cycles  = 0;
    int ovr_cycles  = 0;
    int ferr_cycles = 0;
    logic [7:0] irq_log [$];
    logic [7:0] prev_data = 8'h00;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input int stop_len);
        bus.i_rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            bus.i_rxd = data[i];
            repeat (CPB) tick();
        end
        bus.i_rxd = stop_val;
        repeat (stop_len) tick();
        bus.i_rxd = 1'b1;
    endtask

    // Strobe bookkeeping and per-cycle protocol checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_irq) begin
                irq_cycles++;
                irq_log.push_back(bus.o_rx_data);
                checkOutput("busy_low_at_irq", 32'(bus.o_rx_busy), 32'd0);
            end
            if (bus.o_overrun) begin
                ovr_cycles++;
                checkOutput("busy_low_at_overrun", 32'(bus.o_rx_busy), 32'd0);
            end
            if (bus.o_frame_err) begin
                ferr_cycles++;
                checkOutput("busy_high_at_frame_err", 32'(bus.o_rx_busy), 32'd1);
            end
            if (!bus.o_irq)
                checkOutput("rx_data_hold", 32'(bus.o_rx_data), 32'(prev_data));
        end
        prev_data = bus.o_rx_data;
    end

    initial begin
        int k;
        int busy_count;
        logic [7:0] byte96;

        bus.i_rxd        = 1'b1;
        bus.i_rx_notfull = 1'b1;
        byte96           = 8'h96;

        repeat (3) tick();
        checkOutput("reset_rx_data", 32'(bus.o_rx_data), 32'h00);
        checkOutput("reset_irq", 32'(bus.o_irq), 32'd0);
        checkOutput("reset_busy", 32'(bus.o_rx_busy), 32'd0);
        checkOutput("reset_frame_err", 32'(bus.o_frame_err), 32'd0);
        checkOutput("reset_overrun", 32'(bus.o_overrun), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        applyStimulus(8'hA5, 1'b1, CPB);
        repeat (4) tick();
        checkOutput("single_irq_cycles", irq_cycles, 1);
        checkOutput("single_rx_data", 32'(bus.o_rx_data), 32'hA5);
        checkOutput("single_busy_after", 32'(bus.o_rx_busy), 32'd0);
        checkOutput("single_no_ferr", ferr_cycles, 0);
        checkOutput("single_no_ovr", ovr_cycles, 0);

        bus.i_rx_notfull = 1'b0;
        applyStimulus(8'h5A, 1'b1, CPB);
        repeat (4) tick();
        bus.i_rx_notfull = 1'b1;
        checkOutput("overrun_cycles", ovr_cycles, 1);
        checkOutput("overrun_no_irq", irq_cycles, 1);
        checkOutput("overrun_rx_data_kept", 32'(bus.o_rx_data), 32'hA5);

        applyStimulus(8'h00, 1'b1, CPB);
        applyStimulus(8'hFF, 1'b1, CPB);
        repeat (4) tick();
        checkOutput("b2b_irq_cycles", irq_cycles, 3);
        checkOutput("b2b_first_byte", 32'(irq_log[1]), 32'h00);
        checkOutput("b2b_second_byte", 32'(irq_log[2]), 32'hFF);
        checkOutput("b2b_rx_data", 32'(bus.o_rx_data), 32'hFF);

        applyStimulus(8'h3C, 1'b0, 40);
        k = 0;
        while (k < 20) begin
            tick();
            k++;
            if (!bus.o_rx_busy) break;
        end
        checkOutput("break_busy_fall_cycles", k, 3);
        checkOutput("framing_ferr_cycles", ferr_cycles, 1);
        checkOutput("framing_no_irq", irq_cycles, 3);
        checkOutput("framing_rx_data_kept", 32'(bus.o_rx_data), 32'hFF);
        repeat (4) tick();
        applyStimulus(8'h81, 1'b1, CPB);
        repeat (4) tick();
        checkOutput("after_break_irq_cycles", irq_cycles, 4);
        checkOutput("after_break_byte", 32'(irq_log[3]), 32'h81);

        // 3-cycle low glitch: busy should be high for M+2 cycles only.
        bus.i_rxd  = 1'b0;
        busy_count = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 2) bus.i_rxd = 1'b1;
            if (bus.o_rx_busy) busy_count++;
        end
        checkOutput("false_start_busy_cycles", busy_count, M + 2);
        checkOutput("false_start_no_irq", irq_cycles, 4);
        checkOutput("false_start_no_ferr", ferr_cycles, 1);
        checkOutput("false_start_no_ovr", ovr_cycles, 1);
        checkOutput("false_start_rx_data", 32'(bus.o_rx_data), 32'h81);

        bus.i_rxd = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            bus.i_rxd = byte96[i];
            repeat (CPB) tick();
        end
        bus.i_rxd = byte96[4];
        repeat (M) tick();
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midreset_rx_data", 32'(bus.o_rx_data), 32'h00);
        checkOutput("midreset_irq", 32'(bus.o_irq), 32'd0);
        checkOutput("midreset_busy", 32'(bus.o_rx_busy), 32'd0);
        checkOutput("midreset_frame_err", 32'(bus.o_frame_err), 32'd0);
        checkOutput("midreset_overrun", 32'(bus.o_overrun), 32'd0);
        bus.i_rxd = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        checkOutput("midreset_no_strobe", irq_cycles + ferr_cycles + ovr_cycles, 6);
        applyStimulus(8'h96, 1'b1, CPB);
        repeat (4) tick();
        checkOutput("post_reset_irq_cycles", irq_cycles, 5);
        checkOutput("post_reset_byte", 32'(irq_log[4]), 32'h96);
        checkOutput("post_reset_rx_data", 32'(bus.o_rx_data), 32'h96);
        checkOutput("post_reset_busy", 32'(bus.o_rx_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
